// File: rtl/dice_roll_scheduler.sv
// ---------------------------------------------------------------------------
// dice_roll_scheduler
//
// Arbitrates the single roll engine between seven debounced die buttons and
// roll commands written over the I2C slave application interface. Each roll
// runs IDLE -> SPIN -> DONE -> IDLE. The finished result is held, and the
// control/status registers are exposed to the I2C bus.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   tick          one-cycle 32 Hz prescaler pulse (paces I2C rolls)
//   btn[6:0]      debounced button levels: d4,d6,d8,d10,d12,d20,d100
//   rw, addr      I2C phase (1 = read) and register address
//   wen, wdata    one-cycle write strobe and write data
//   rdata_used    one-cycle pulse when the slave has consumed rdata
//   rdata         registered read data (one cycle behind addr)
//   busy          roll in progress (state is not IDLE)
//   result_valid  an unread result is held
//   tens, ones    registered BCD digits of the displayed value
//
// Register map: 0x00 CTRL (W, reads back), 0x01 SPIN (R/W),
//               0x02 STATUS (R), 0x03 RESULT (R); others read 0x00.
// ---------------------------------------------------------------------------
module dice_roll_scheduler #(
    parameter logic [7:0] DEFAULT_SPIN = 8'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [6:0] btn,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic       wen,
    input  logic [7:0] wdata,
    input  logic       rdata_used,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       result_valid,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_SPIN   = 8'h01;
    localparam logic [7:0] ADDR_STATUS = 8'h02;
    localparam logic [7:0] ADDR_RESULT = 8'h03;

    // Number of die faces for a select code; code 7 aliases d100.
    function automatic logic [6:0] sides(input logic [2:0] sel);
        case (sel)
            3'd0:    sides = 7'd4;
            3'd1:    sides = 7'd6;
            3'd2:    sides = 7'd8;
            3'd3:    sides = 7'd10;
            3'd4:    sides = 7'd12;
            3'd5:    sides = 7'd20;
            default: sides = 7'd100;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [7:0] ctrl_q;
    logic [7:0] spin_q;
    logic [7:0] tcnt_q;
    logic [6:0] cnt_q;
    logic [6:0] result_q;
    logic [2:0] die_q;       // die of the current/last roll; equals button index for button rolls
    logic       src_i2c_q;
    logic       pending_q;
    logic       valid_q;

    logic       grant_btn, grant_i2c;
    logic [2:0] btn_idx;
    logic [2:0] grant_die;
    logic       ctrl_wr, spin_wr, read_clear;
    logic [6:0] disp_val, disp_mod;
    logic [7:0] rdata_d;

    assign busy         = (state_q != IDLE);
    assign result_valid = valid_q;

    assign ctrl_wr    = wen && (addr == ADDR_CTRL);
    assign spin_wr    = wen && (addr == ADDR_SPIN);
    assign read_clear = rdata_used && rw && (addr == ADDR_RESULT);

    // Lowest-index pressed button wins: scan from the top so the last hit is the lowest.
    always_comb begin
        btn_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (btn[i]) btn_idx = 3'(i);
        end
    end

    assign grant_die = grant_btn ? btn_idx : ctrl_q[2:0];

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; without it some
        // branch would leave a value unassigned and a latch would be inferred.
        state_d   = state_q;
        grant_btn = 1'b0;
        grant_i2c = 1'b0;
        case (state_q)
            IDLE: begin
                if (|btn) begin
                    grant_btn = 1'b1;
                    state_d   = SPIN;
                end else if (pending_q) begin
                    grant_i2c = 1'b1;
                    state_d   = SPIN;
                end
            end
            SPIN: begin
                if (src_i2c_q) begin
                    if (tick && (tcnt_q <= 8'd1)) state_d = DONE;
                end else if (!btn[die_q]) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Roll datapath and registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            ctrl_q    <= 8'h00;
            spin_q    <= DEFAULT_SPIN;
            tcnt_q    <= 8'd0;
            cnt_q     <= 7'd0;
            result_q  <= 7'd0;
            die_q     <= 3'd0;
            src_i2c_q <= 1'b0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_q <= wdata;
            if (spin_wr) spin_q <= wdata;

            // Single-deep request; a start written on the grant cycle re-arms it.
            if (grant_i2c)            pending_q <= 1'b0;
            if (ctrl_wr && wdata[7])  pending_q <= 1'b1;

            if (grant_btn || grant_i2c) begin
                src_i2c_q <= grant_i2c;
                die_q     <= grant_die;
                cnt_q     <= sides(grant_die);
                tcnt_q    <= (spin_q == 8'd0) ? 8'd1 : spin_q;
            end else if (state_q == SPIN) begin
                // cnt freezes on the exit cycle so RESULT is the value seen at release.
                if (state_d == SPIN)
                    cnt_q <= (cnt_q <= 7'd1) ? sides(die_q) : cnt_q - 7'd1;
                if (src_i2c_q && tick && (tcnt_q != 8'd0))
                    tcnt_q <= tcnt_q - 8'd1;
            end

            if (state_q == DONE) result_q <= cnt_q;

            // A completing roll outranks a coincident read-clear.
            if (state_q == DONE)  valid_q <= 1'b1;
            else if (read_clear)  valid_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Read port and display
    // -----------------------------------------------------------------------
    always_comb begin
        rdata_d = 8'h00;
        case (addr)
            ADDR_CTRL:   rdata_d = ctrl_q;
            ADDR_SPIN:   rdata_d = spin_q;
            ADDR_STATUS: rdata_d = {1'b0, die_q, src_i2c_q, valid_q, pending_q, busy};
            ADDR_RESULT: rdata_d = {1'b0, result_q};
            default:     rdata_d = 8'h00;
        endcase
    end

    // Live cnt while rolling (in DONE cnt already equals the new result).
    assign disp_val = (state_q == IDLE) ? result_q : cnt_q;
    assign disp_mod = (disp_val >= 7'd100) ? disp_val - 7'd100 : disp_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
            tens  <= 4'd0;
            ones  <= 4'd0;
        end else begin
            rdata <= rdata_d;
            tens  <= 4'(disp_mod / 7'd10);
            ones  <= 4'(disp_mod % 7'd10);
        end
    end

endmodule
